// File: rtl/ai_act_pipe.sv
// Multi-lane two-stage activation pipeline (PASS/RELU/LEAKY/HSIGMOID/HTANH/RELU6) with valid/ready and an op counter.
// Build option: define AI_ACT_ROUND_EN to round the LEAKY and HSIGMOID shifts to nearest instead of truncating.

module ai_act_lane #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic [2:0]    op_i,
    input  logic          en_i,
    input  logic [DW-1:0] x_i,
    output logic [DW-1:0] y_o
);
    localparam int EW = DW + 2;

    localparam logic [2:0] OP_PASS     = 3'd0;
    localparam logic [2:0] OP_RELU     = 3'd1;
    localparam logic [2:0] OP_LEAKY    = 3'd2;
    localparam logic [2:0] OP_HSIGMOID = 3'd3;
    localparam logic [2:0] OP_HTANH    = 3'd4;
    localparam logic [2:0] OP_RELU6    = 3'd5;

    localparam logic signed [EW-1:0] ZERO    = '0;
    localparam logic signed [EW-1:0] ONE     = EW'(1 << FRAC);
    localparam logic signed [EW-1:0] NEG_ONE = -ONE;
    localparam logic signed [EW-1:0] HALF    = EW'(1 << (FRAC - 1));
    localparam logic signed [EW-1:0] SIX     = EW'(6 << FRAC);
    localparam logic signed [EW-1:0] SMAX    = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN    = {3'b111, {(DW-1){1'b0}}};

`ifdef AI_ACT_ROUND_EN
    // Half an output LSB added ahead of the shift turns floor into round-to-nearest.
    localparam logic signed [EW-1:0] RND3 = EW'(4);
    localparam logic signed [EW-1:0] RND2 = EW'(2);
`else
    localparam logic signed [EW-1:0] RND3 = '0;
    localparam logic signed [EW-1:0] RND2 = '0;
`endif

    function automatic logic signed [EW-1:0] clamp(
        input logic signed [EW-1:0] v,
        input logic signed [EW-1:0] lo,
        input logic signed [EW-1:0] hi
    );
        clamp = v;
        if (v < lo)
            clamp = lo;
        else if (v > hi)
            clamp = hi;
    endfunction

    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] shr3;
    logic signed [EW-1:0] shr2;
    logic signed [EW-1:0] raw;
    logic signed [EW-1:0] sat;
    logic                 legal;
    logic                 lane_unused;

    assign xe    = {{2{x_i[DW-1]}}, x_i};
    assign shr3  = (xe + RND3) >>> 3;
    assign shr2  = (xe + RND2) >>> 2;
    assign legal = (op_i <= OP_RELU6);

    always_comb begin
        raw = ZERO;
        case (op_i)
            OP_PASS:     raw = xe;
            OP_RELU:     raw = (xe < ZERO) ? ZERO : xe;
            OP_LEAKY:    raw = (xe < ZERO) ? shr3 : xe;
            OP_HSIGMOID: raw = clamp(shr2 + HALF, ZERO, ONE);
            OP_HTANH:    raw = clamp(xe, NEG_ONE, ONE);
            OP_RELU6:    raw = clamp(xe, ZERO, SIX);
            default:     raw = ZERO;
        endcase
    end

    // Final saturation to the lane width; the guard bits are dropped afterwards.
    assign sat         = clamp(raw, SMIN, SMAX);
    assign lane_unused = ^sat[EW-1:DW];
    assign y_o         = (en_i && legal) ? sat[DW-1:0] : '0;

endmodule

module ai_act_pipe #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [LANES-1:0]    in_mask,
    input  logic [LANES*DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic                out_err,
    output logic                busy,
    input  logic                clear_count,
    output logic [31:0]         op_count
);
    // vld_pipe_q[0] is the S1 valid, vld_pipe_q[1] the S2/output valid.
    logic [1:0]                 vld_pipe_q, vld_pipe_d;
    logic [2:0]                 s1_op_q;
    logic [LANES-1:0]           s1_mask_q;
    logic [LANES-1:0][DW-1:0]   s1_data_q;
    logic [LANES-1:0][DW-1:0]   lane_y;
    logic [LANES-1:0][DW-1:0]   out_data_q;
    logic                       out_err_q;
    logic [31:0]                cnt_q, cnt_d;
    logic                       stall;
    logic                       s1_err;

    assign stall  = vld_pipe_q[1] && !out_ready;
    assign s1_err = (s1_op_q > 3'd5);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ai_act_lane #(
            .DW   (DW),
            .FRAC (FRAC)
        ) u_lane (
            .op_i (s1_op_q),
            .en_i (s1_mask_q[i]),
            .x_i  (s1_data_q[i]),
            .y_o  (lane_y[i])
        );
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (!stall)
            vld_pipe_d = {vld_pipe_q[0], in_valid};
    end

    // Clear beats a same-cycle completion; the counter pins at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_count)
            cnt_d = '0;
        else if (vld_pipe_q[1] && out_ready && !out_err_q && !(&cnt_q))
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_op_q    <= '0;
            s1_mask_q  <= '0;
            s1_data_q  <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
            if (!stall) begin
                if (in_valid) begin
                    s1_op_q   <= in_op;
                    s1_mask_q <= in_mask;
                    s1_data_q <= in_data;
                end
                if (vld_pipe_q[0]) begin
                    out_data_q <= lane_y;
                    out_err_q  <= s1_err;
                end
            end
        end
    end

    assign in_ready  = !stall;
    assign out_valid = vld_pipe_q[1];
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign busy      = |vld_pipe_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_ai_act_pipe.sv
// Randomized and directed bench for ai_act_pipe against a queue-based arithmetic reference model.
module tb_ai_act_pipe;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ONE   = 1 << FRAC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [3:0]  in_mask = 4'd0;
    logic [63:0] in_data = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_err;
    logic        busy;
    logic        clear_count = 1'b0;
    logic [31:0] op_count;

    ai_act_pipe #(.LANES(LANES), .DW(DW), .FRAC(FRAC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_mask     (in_mask),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .busy        (busy),
        .clear_count (clear_count),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t q[$];

    function automatic int fdiv(input int a, input int b);
        int r;
        r = a / b;
        if ((a % b != 0) && (a < 0)) r = r - 1;
        return r;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [15:0] ref_lane(input logic [2:0] op, input logic en, input logic [15:0] xr);
        int x, y, r3, r2;
        x = $signed(xr);
`ifdef AI_ACT_ROUND_EN
        r3 = 4; r2 = 2;
`else
        r3 = 0; r2 = 0;
`endif
        case (op)
            3'd0: y = x;
            3'd1: y = (x < 0) ? 0 : x;
            3'd2: y = (x < 0) ? fdiv(x + r3, 8) : x;
            3'd3: y = clampi(fdiv(x + r2, 4) + ONE / 2, 0, ONE);
            3'd4: y = clampi(x, -ONE, ONE);
            3'd5: y = clampi(x, 0, 6 * ONE);
            default: y = 0;
        endcase
        if (!en) y = 0;
        y = clampi(y, -32768, 32767);
        return 16'(y);
    endfunction

    function automatic exp_t ref_vec(input logic [2:0] op, input logic [3:0] m, input logic [63:0] d);
        exp_t e;
        e.d = '0;
        for (int i = 0; i < LANES; i++)
            e.d[i*DW +: DW] = ref_lane(op, m[i], d[i*DW +: DW]);
        e.e = (op > 3'd5);
        return e;
    endfunction

    int          cnt_m = 0;
    bit          last_acc, last_hs, hs_err, prev_stall;
    int          acc_cyc, hs_cyc;
    logic [63:0] hs_data, prev_data;

    // One cycle: observe handshakes #1 after the falling edge, update the model, then wait for the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        chk("op_count", 64'(op_count), 64'(cnt_m));
        chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, prev_data);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        last_hs = 0;
        last_acc = 0;
        if (out_valid && out_ready) begin
            last_hs = 1; hs_cyc = cyc; hs_data = out_data; hs_err = out_err;
            if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("data", out_data, e.d);
                chk("err", 64'(out_err), 64'(e.e));
                if (!e.e) cnt_m++;
            end
        end
        if (clear_count) cnt_m = 0;
        if (in_valid && in_ready) begin
            last_acc = 1; acc_cyc = cyc;
            q.push_back(ref_vec(in_op, in_mask, in_data));
        end
        @(negedge clk);
    endtask

    task automatic one(input string tag, input logic [2:0] op, input logic [3:0] m,
                       input logic [63:0] d, input logic [63:0] ex);
        int n;
        in_valid = 1; in_op = op; in_mask = m; in_data = d; out_ready = 1;
        tick();
        chk({tag, "_acc"}, 64'(last_acc), 64'd1);
        in_valid = 0;
        n = 0;
        do begin tick(); n++; end while (!last_hs && n < 8);
        chk({tag, "_seen"}, 64'(last_hs), 64'd1);
        chk({tag, "_lat"}, 64'(hs_cyc - acc_cyc), 64'd2);
        chk({tag, "_val"}, hs_data, ex);
    endtask

    function automatic logic [15:0] pick_val();
        logic [15:0] tbl [10];
        tbl = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h0100,
                16'hFF00, 16'h0600, 16'h0601, 16'hFFFD, 16'h0001};
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 9)];
        return 16'($urandom);
    endfunction

    initial begin
        int issued, t, n, cnt_before;
        bit saw, pend;
        logic [63:0] leaky_exp;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        rst_n = 1;
        @(negedge clk);

        one("relu", 3'd1, 4'hF, {16'h8000, 16'h0000, 16'h0200, 16'hFE00},
            {16'h0000, 16'h0000, 16'h0200, 16'h0000});
        chk("relu_count", 64'(op_count), 64'd1);
        one("hsig", 3'd3, 4'hF, {16'h7FFF, 16'hFD00, 16'h0000, 16'h0200},
            {16'h0100, 16'h0000, 16'h0080, 16'h0100});
        one("htanh", 3'd4, 4'hF, {16'h7FFF, 16'h0100, 16'h0080, 16'hFE00},
            {16'h0100, 16'h0100, 16'h0080, 16'hFF00});
        one("relu6", 3'd5, 4'hF, {16'h0000, 16'h0000, 16'h0000, 16'h0800},
            {16'h0000, 16'h0000, 16'h0000, 16'h0600});
`ifdef AI_ACT_ROUND_EN
        leaky_exp = {16'h0100, 16'h0100, 16'hFF00, 16'h0000};
`else
        leaky_exp = {16'h0100, 16'h0100, 16'hFF00, 16'hFFFF};
`endif
        one("leaky", 3'd2, 4'hF, {16'h0100, 16'h0100, 16'hF800, 16'hFFFD}, leaky_exp);
        cnt_before = int'(op_count);
        one("illegal", 3'd7, 4'hF, 64'h1234_5678_9ABC_DEF0, 64'd0);
        chk("illegal_err", 64'(hs_err), 64'd1);
        chk("illegal_count", 64'(op_count), 64'(cnt_before));
        one("mask", 3'd0, 4'b0101, {16'd4, 16'd3, 16'd2, 16'd1},
            {16'd0, 16'd3, 16'd0, 16'd1});

        // Back-pressure: five requests, consumer stalls for cycles 3..6.
        clear_count = 1; tick(); clear_count = 0;
        issued = 0; t = 0; saw = 0;
        in_data = {pick_val(), pick_val(), pick_val(), pick_val()};
        while ((issued < 5 || q.size() > 0) && t < 40) begin
            in_valid = (issued < 5);
            in_op = 3'(issued);
            in_mask = 4'hF;
            out_ready = !(t >= 3 && t <= 6);
            tick();
            saw |= prev_stall;
            if (last_acc) begin
                issued++;
                in_data = {pick_val(), pick_val(), pick_val(), pick_val()};
            end
            t++;
        end
        in_valid = 0; out_ready = 1;
        chk("bp_stall_seen", 64'(saw), 64'd1);
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_count", 64'(op_count), 64'd5);

        // Reset with both stages occupied.
        out_ready = 0; in_valid = 1; in_op = 3'd1; in_mask = 4'hF; in_data = 64'h0001_0002_0003_0004;
        tick(); tick();
        in_valid = 0;
        chk("full_busy", 64'(busy), 64'd1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; q.delete(); cnt_m = 0; prev_stall = 0; out_ready = 1;
        repeat (4) begin
            tick();
            chk("post_rst_valid", 64'(out_valid), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        chk("post_rst_count", 64'(op_count), 64'd0);

        // Clear coinciding with a completing handshake.
        one("pre_clr", 3'd0, 4'hF, 64'd5, 64'd5);
        in_valid = 1; in_op = 3'd1; in_data = 64'd7;
        tick();
        in_valid = 0;
        n = 0;
        do begin clear_count = out_valid; tick(); n++; end while (!last_hs && n < 8);
        clear_count = 0;
        chk("clr_hs_seen", 64'(last_hs), 64'd1);
        chk("clr_count", 64'(op_count), 64'd0);

        // Randomized traffic with random back-pressure and occasional clears.
        pend = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 9) < 8) begin
                pend = 1;
                in_op = 3'($urandom_range(0, 7));
                in_mask = 4'($urandom);
                in_data = {pick_val(), pick_val(), pick_val(), pick_val()};
            end
            in_valid = pend;
            out_ready = ($urandom_range(0, 9) < 7);
            clear_count = ($urandom_range(0, 29) == 0);
            tick();
            if (last_acc) pend = 0;
        end
        in_valid = 0; clear_count = 0; out_ready = 1;
        n = 0;
        while (q.size() > 0 && n < 10) begin tick(); n++; end
        chk("rand_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
